// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: memory op codes,
// FSM states and parameter limits.
package mem_stage_lsu_pkg;

  typedef enum logic [3:0] {
    NO_MEM = 4'd0,
    LB     = 4'd1,
    LH     = 4'd2,
    LW     = 4'd3,
    LBU    = 4'd4,
    LHU    = 4'd5,
    SB     = 4'd6,
    SH     = 4'd7,
    SW     = 4'd8
  } memOp_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsuState_e;

  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 4;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 4096;

  // Unused encodings behave exactly like NO_MEM.
  function automatic memOp_e decodeMemOp(input logic [3:0] code);
    if (code > 4'd8) return NO_MEM;
    return memOp_e'(code);
  endfunction

  function automatic logic isLoad(input memOp_e op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic isStore(input memOp_e op);
    return op inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_dmem.sv
// Single-port data memory, 32-bit words, per-byte write enable and a
// registered read port. Contents are never reset.
module dmem_1p_bytewe #(
  parameter int DEPTH  = 816,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // A write cycle leaves rdata holding the last read, so a stalled load keeps its data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: address checks, store lane steering, load
// extraction/extension and a small wait FSM for multi-cycle load latency.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DEPTH = 816,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validM,
  input  logic        regWriteEnM,
  input  logic [1:0]  resultSrcM,
  input  logic [4:0]  rdM,
  input  logic [3:0]  memOpTypeM,
  input  logic [31:0] aluResultM,
  input  logic [31:0] memWriteDataM,
  output logic        stallM,
  output logic        validW,
  output logic        regWriteEnW,
  output logic [1:0]  resultSrcW,
  output logic [4:0]  rdW,
  output logic [31:0] aluResultW,
  output logic [31:0] memReadDataW,
  output logic        misalignW,
  output logic        accessFaultW
);

  localparam int DEPTH_EFF = (DEPTH < DEPTH_MIN) ? DEPTH_MIN :
                             (DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH;
  localparam int LAT_EFF   = (LAT < LAT_MIN) ? LAT_MIN :
                             (LAT > LAT_MAX) ? LAT_MAX : LAT;
  localparam int ADDR_W    = $clog2(DEPTH_EFF);
  localparam int CNT_W     = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT_EFF > 1) ? LAT_EFF - 2 : 0);

  lsuState_e         state;
  logic [CNT_W-1:0]  cnt;

  memOp_e            opM;
  logic [1:0]        offsetM;
  logic [ADDR_W-1:0] wordIdxM;
  logic              loadM;
  logic              storeM;
  logic              misalignM;
  logic              faultM;
  logic              accessM;
  logic [3:0]        byteWeM;
  logic [31:0]       wdataM;

  logic              ramEn;
  logic [3:0]        ramWe;
  logic [31:0]       ramRdata;

  logic              pendRegWrite;
  logic [1:0]        pendResultSrc;
  logic [4:0]        pendRd;
  logic [31:0]       pendAlu;
  memOp_e            pendOp;
  logic [1:0]        pendOffset;

  logic              loadW;
  memOp_e            opW;
  logic [1:0]        offsetW;
  logic [7:0]        laneByte;
  logic [15:0]       laneHalf;

  assign stallM = (state == WAIT);

  // Decode, alignment/range checks and store lane steering for the M-stage op.
  always_comb begin
    opM      = decodeMemOp(memOpTypeM);
    offsetM  = aluResultM[1:0];
    wordIdxM = aluResultM[ADDR_W+1:2];
    loadM    = isLoad(opM);
    storeM   = isStore(opM);

    misalignM = validM &&
                (((opM == LH || opM == LHU || opM == SH) && offsetM[0]) ||
                 ((opM == LW || opM == SW) && (offsetM != 2'b00)));
    faultM    = validM && (loadM || storeM) && !misalignM &&
                ((32'(wordIdxM) >= 32'(DEPTH_EFF)) ||
                 (aluResultM[31:ADDR_W+2] != '0));
    accessM   = validM && (loadM || storeM) && !misalignM && !faultM &&
                (state == IDLE);

    byteWeM = 4'b0000;
    wdataM  = memWriteDataM;
    case (opM)
      SB: begin
        byteWeM = 4'b0001 << offsetM;
        wdataM  = {4{memWriteDataM[7:0]}};
      end
      SH: begin
        byteWeM = offsetM[1] ? 4'b1100 : 4'b0011;
        wdataM  = {2{memWriteDataM[15:0]}};
      end
      SW:      byteWeM = 4'b1111;
      default: byteWeM = 4'b0000;
    endcase
  end

  // Memory is held off entirely while reset is high.
  assign ramEn = accessM && !reset;
  assign ramWe = (accessM && storeM && !reset) ? byteWeM : 4'b0000;

  dmem_1p_bytewe #(
    .DEPTH (DEPTH_EFF),
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .en   (ramEn),
    .we   (ramWe),
    .addr (wordIdxM),
    .wdata(wdataM),
    .rdata(ramRdata)
  );

  // Wait FSM and W-stage registers; a long load parks its info in pend* until release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      validW        <= 1'b0;
      regWriteEnW   <= 1'b0;
      resultSrcW    <= 2'b00;
      rdW           <= 5'd0;
      aluResultW    <= 32'd0;
      misalignW     <= 1'b0;
      accessFaultW  <= 1'b0;
      loadW         <= 1'b0;
      opW           <= NO_MEM;
      offsetW       <= 2'b00;
      pendRegWrite  <= 1'b0;
      pendResultSrc <= 2'b00;
      pendRd        <= 5'd0;
      pendAlu       <= 32'd0;
      pendOp        <= NO_MEM;
      pendOffset    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accessM && loadM && (LAT_EFF > 1)) begin
            state         <= WAIT;
            cnt           <= CNT_LOAD;
            pendRegWrite  <= regWriteEnM;
            pendResultSrc <= resultSrcM;
            pendRd        <= rdM;
            pendAlu       <= aluResultM;
            pendOp        <= opM;
            pendOffset    <= offsetM;
            validW        <= 1'b0;
            regWriteEnW   <= 1'b0;
            resultSrcW    <= 2'b00;
            rdW           <= 5'd0;
            aluResultW    <= 32'd0;
            misalignW     <= 1'b0;
            accessFaultW  <= 1'b0;
            loadW         <= 1'b0;
            opW           <= NO_MEM;
            offsetW       <= 2'b00;
          end else begin
            validW        <= validM;
            regWriteEnW   <= validM && regWriteEnM && !misalignM && !faultM;
            resultSrcW    <= validM ? resultSrcM : 2'b00;
            rdW           <= validM ? rdM : 5'd0;
            aluResultW    <= validM ? aluResultM : 32'd0;
            misalignW     <= misalignM;
            accessFaultW  <= faultM;
            loadW         <= accessM && loadM;
            opW           <= opM;
            offsetW       <= offsetM;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= IDLE;
            validW        <= 1'b1;
            regWriteEnW   <= pendRegWrite;
            resultSrcW    <= pendResultSrc;
            rdW           <= pendRd;
            aluResultW    <= pendAlu;
            loadW         <= 1'b1;
            opW           <= pendOp;
            offsetW       <= pendOffset;
          end else begin
            cnt           <= cnt - 1'b1;
            validW        <= 1'b0;
            regWriteEnW   <= 1'b0;
            resultSrcW    <= 2'b00;
            rdW           <= 5'd0;
            aluResultW    <= 32'd0;
            loadW         <= 1'b0;
            opW           <= NO_MEM;
            offsetW       <= 2'b00;
          end
          misalignW    <= 1'b0;
          accessFaultW <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane extraction and extension from the registered read word.
  always_comb begin
    case (offsetW)
      2'd0:    laneByte = ramRdata[7:0];
      2'd1:    laneByte = ramRdata[15:8];
      2'd2:    laneByte = ramRdata[23:16];
      default: laneByte = ramRdata[31:24];
    endcase
    laneHalf = offsetW[1] ? ramRdata[31:16] : ramRdata[15:0];

    memReadDataW = 32'd0;
    if (loadW) begin
      case (opW)
        LB:      memReadDataW = {{24{laneByte[7]}}, laneByte};
        LBU:     memReadDataW = {24'd0, laneByte};
        LH:      memReadDataW = {{16{laneHalf[15]}}, laneHalf};
        LHU:     memReadDataW = {16'd0, laneHalf};
        LW:      memReadDataW = ramRdata;
        default: memReadDataW = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 816, meaning data-memory size in 32-bit words (range 2..4096).
REQ-002 SHALL have parameter LAT, default 1, meaning load latency in cycles (range 1..4).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- validM  in  1  M-stage instruction present.
- regWriteEnM  in  1  register write enable, passed through.
- resultSrcM  in  2  W-stage result select, passed through.
- rdM  in  5  destination register.
- memOpTypeM  in  4  memory operation code.
- aluResultM  in  32  byte address.
- memWriteDataM  in  32  store data, right-aligned.
- stallM  out  1  hold the upstream stages and inputs this cycle.
- validW  out  1  W-stage instruction present.
- regWriteEnW  out  1  register write enable.
- resultSrcW  out  2  result select.
- rdW  out  5  destination register.
- aluResultW  out  32  address/ALU result.
- memReadDataW  out  32  registered, aligned, extended load data.
- misalignW  out  1  access misaligned; access suppressed.
- accessFaultW  out  1  address beyond DEPTH; access suppressed.

Function
REQ-005 SHALL decode memOpTypeM: NO_MEM=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; codes 9..15 are treated as NO_MEM.
REQ-006 SHALL compute the word index as aluResultM[ADDR_W+1:2], where ADDR_W = clog2(DEPTH), and the byte offset as aluResultM[1:0].
REQ-007 SHALL flag misalignment for LH/LHU/SH with offset bit0=1 and for LW/SW with offset!=0; byte operations are never misaligned.
REQ-008 SHALL flag an access fault when the access is not misaligned and the word index is >= DEPTH or aluResultM[31:ADDR_W+2] is nonzero.
REQ-009 On a flagged access, SHALL perform no memory write, force regWriteEnW=0, and set misalignW or accessFaultW for exactly one W cycle.
REQ-010 Stores SHALL write only the addressed lanes, in one cycle, with no stall:
- SB writes lane = offset with memWriteDataM[7:0].
- SH writes lanes offset, offset+1 with memWriteDataM[15:0].
- SW writes all four lanes.
REQ-011 Loads SHALL extract the addressed byte/halfword and extend it: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
REQ-012 A load in the cycle immediately after a store to the same word SHALL return the post-store data.
REQ-013 SHALL implement FSM {IDLE, WAIT} with down-counter cnt of width clog2(LAT).
REQ-014 IDLE -> WAIT when a valid, unflagged load is accepted and LAT>1; cnt is loaded with LAT-2.
REQ-015 In WAIT, SHALL assert stallM, decrement cnt, and return to IDLE when cnt=0.
REQ-016 W outputs SHALL update in the cycle after WAIT exits; total load latency is LAT cycles.
REQ-017 During WAIT, SHALL ignore M inputs, issue no new memory access, and present validW=0 and regWriteEnW=0 (bubble).
REQ-018 With LAT=1, stallM SHALL stay constantly 0 and every operation SHALL reach W exactly one cycle after M.
REQ-019 stallM SHALL be combinational from FSM state only, never from M inputs.
REQ-020 validM=0 SHALL produce validW=0, regWriteEnW=0, no memory access and no flags.
REQ-021 Non-load W outputs SHALL carry memReadDataW=0.

Reset
REQ-022 Reset SHALL force immediately, independent of clk:
- FSM to IDLE and cnt=0.
- stallM=0, validW=0, regWriteEnW=0, misalignW=0, accessFaultW=0.
- resultSrcW=0, rdW=0, aluResultW=0, memReadDataW=0.
REQ-023 Reset asserted during WAIT SHALL drop the pending load.
REQ-024 Reset SHALL not initialise memory contents, and no write SHALL occur while reset is high.

Structure
REQ-025 The memOpType encodings and the LAT/DEPTH limits SHALL live in the shared definitions header; no local redefinition.
REQ-026 The storage array (one port, per-byte write enable, registered read, parameter DEPTH) SHALL be a sub-module named dmem_1p_bytewe.
REQ-027 Alignment, lane selection and extension SHALL be in mem_stage_lsu itself.

Verification
REQ-028 SW 0x8000_00F1 to addr 0x10, then LB/LBU/LH/LHU at 0x10 -> 0xFFFF_FFF1, 0x0000_00F1, 0x0000_00F1, 0x0000_00F1.
REQ-029 SW 0x1122_3344 to 0x20, SB 0xAA to 0x22, LW 0x20 next cycle -> 0x11AA_3344.
REQ-030 LH at 0x21, SW at 0x22 -> misalignW=1 for one cycle, regWriteEnW=0, memory word at 0x20 unchanged.
REQ-031 DEPTH=816: LW at 0xCC0 -> accessFaultW=1; LW at 0xCBC -> normal data.
REQ-032 LAT=3: a load accepted in cycle n -> stallM=1 in n+1..n+2, validW=1 with data in n+3; reset pulsed in n+1 -> validW never asserted.
